// File: rtl/sram_wr_ctrl.sv
// Frame-buffer write controller: turns decoder window/pixel strobes into single-cycle
// SRAM writes with ST7735-style cursor wrap, plus a full-frame clear sweep.
//
// state | meaning
// IDLE  | accepting pixel writes at the window cursor
// CLEAR | sweeping zeros over the whole frame, one word per cycle
module sram_wr_ctrl #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 128,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_pixel_data,
  input  logic [31:0]       i_col_addr,
  input  logic [31:0]       i_row_addr,
  input  logic              i_sram_clr_req,
  input  logic              i_sram_write_req,
  input  logic              i_sram_waddr_set_req,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_we,
  output logic              o_busy,
  output logic              o_clr_done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0] SWEEP_END = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [ADDR_W:0] H_MUL     = (ADDR_W+1)'(H_ACTIVE);
  localparam logic [15:0]     X_MAX     = 16'(H_ACTIVE - 1);
  localparam logic [15:0]     Y_MAX     = 16'(V_ACTIVE - 1);

  state_t              state_q, state_nxt;
  logic                clr_prev, wr_prev, set_prev;
  logic [15:0]         xs_q, xe_q, ys_q, ye_q, cx_q, cy_q;
  logic [15:0]         xs_nxt, xe_nxt, ys_nxt, ye_nxt, cx_nxt, cy_nxt;
  logic [ADDR_W:0]     cnt_q, cnt_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                we_nxt, busy_nxt, done_nxt;
  logic                clr_ev, set_ev, wr_ev;
  logic [ADDR_W:0]     lin_addr;

  // One event per stretched pulse; lower-priority coincident events are dropped
  assign clr_ev = i_sram_clr_req & ~clr_prev;
  assign set_ev = i_sram_waddr_set_req & ~set_prev & ~clr_ev;
  assign wr_ev  = i_sram_write_req & ~wr_prev & ~clr_ev & ~set_ev;

  assign lin_addr = (ADDR_W+1)'(cy_q) * H_MUL + (ADDR_W+1)'(cx_q);

  always_comb begin
    state_nxt = state_q;
    xs_nxt    = xs_q;
    xe_nxt    = xe_q;
    ys_nxt    = ys_q;
    ye_nxt    = ye_q;
    cx_nxt    = cx_q;
    cy_nxt    = cy_q;
    cnt_nxt   = cnt_q;
    addr_nxt  = o_sram_addr;
    wdata_nxt = o_sram_wdata;
    we_nxt    = 1'b0;
    busy_nxt  = o_busy;
    done_nxt  = 1'b0;

    if (clr_ev) begin
      // First sweep word goes out on the same edge that enters CLEAR
      state_nxt = CLEAR;
      xs_nxt    = '0;
      xe_nxt    = X_MAX;
      ys_nxt    = '0;
      ye_nxt    = Y_MAX;
      cx_nxt    = '0;
      cy_nxt    = '0;
      busy_nxt  = 1'b1;
      we_nxt    = 1'b1;
      addr_nxt  = '0;
      wdata_nxt = '0;
      cnt_nxt   = (ADDR_W+1)'(1);
    end else begin
      if (set_ev) begin
        xs_nxt = i_col_addr[31:16];
        xe_nxt = i_col_addr[15:0];
        ys_nxt = i_row_addr[31:16];
        ye_nxt = i_row_addr[15:0];
        cx_nxt = i_col_addr[31:16];
        cy_nxt = i_row_addr[31:16];
      end
      case (state_q)
        IDLE: begin
          if (wr_ev) begin
            if (cx_q < 16'(H_ACTIVE) && cy_q < 16'(V_ACTIVE)) begin
              we_nxt    = 1'b1;
              addr_nxt  = ADDR_W'(lin_addr);
              wdata_nxt = i_pixel_data;
            end
            if (cx_q >= xe_q) begin
              cx_nxt = xs_q;
              cy_nxt = (cy_q >= ye_q) ? ys_q : cy_q + 16'd1;
            end else begin
              cx_nxt = cx_q + 16'd1;
            end
          end
        end
        CLEAR: begin
          if (cnt_q == SWEEP_END) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            we_nxt    = 1'b1;
            addr_nxt  = ADDR_W'(cnt_q);
            wdata_nxt = '0;
            cnt_nxt   = cnt_q + (ADDR_W+1)'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      clr_prev     <= 1'b0;
      wr_prev      <= 1'b0;
      set_prev     <= 1'b0;
      xs_q         <= '0;
      xe_q         <= X_MAX;
      ys_q         <= '0;
      ye_q         <= Y_MAX;
      cx_q         <= '0;
      cy_q         <= '0;
      cnt_q        <= '0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_we    <= 1'b0;
      o_busy       <= 1'b0;
      o_clr_done   <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      clr_prev     <= i_sram_clr_req;
      wr_prev      <= i_sram_write_req;
      set_prev     <= i_sram_waddr_set_req;
      xs_q         <= xs_nxt;
      xe_q         <= xe_nxt;
      ys_q         <= ys_nxt;
      ye_q         <= ye_nxt;
      cx_q         <= cx_nxt;
      cy_q         <= cy_nxt;
      cnt_q        <= cnt_nxt;
      o_sram_addr  <= addr_nxt;
      o_sram_wdata <= wdata_nxt;
      o_sram_we    <= we_nxt;
      o_busy       <= busy_nxt;
      o_clr_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Directed bench for sram_wr_ctrl: vector table for cursor/window writes, plus
// hand-written sequences for stretched pulses, clear sweeps and async reset.
module tb_sram_wr_ctrl;

  localparam int H = 160;
  localparam int V = 128;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int TOTAL = H * V;

  logic          i_clk;
  logic          i_rst_n;
  logic [DW-1:0] i_pixel_data;
  logic [31:0]   i_col_addr;
  logic [31:0]   i_row_addr;
  logic          i_sram_clr_req;
  logic          i_sram_write_req;
  logic          i_sram_waddr_set_req;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_wdata;
  logic          o_sram_we;
  logic          o_busy;
  logic          o_clr_done;

  sram_wr_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_pixel_data         (i_pixel_data),
    .i_col_addr           (i_col_addr),
    .i_row_addr           (i_row_addr),
    .i_sram_clr_req       (i_sram_clr_req),
    .i_sram_write_req     (i_sram_write_req),
    .i_sram_waddr_set_req (i_sram_waddr_set_req),
    .o_sram_addr          (o_sram_addr),
    .o_sram_wdata         (o_sram_wdata),
    .o_sram_we            (o_sram_we),
    .o_busy               (o_busy),
    .o_clr_done           (o_clr_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          set;
    logic [31:0] col;
    logic [31:0] row;
    logic [15:0] data;
    bit          exp_we;
    int          exp_addr;
  } vec_t;

  vec_t vecs[18];
  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [AW-1:0] aq[$];
  logic [DW-1:0] dq[$];

  // Pixel writes (outside the sweep) and done pulses, observed on the falling edge
  always @(negedge i_clk) begin
    if (o_sram_we && !o_busy) begin
      aq.push_back(o_sram_addr);
      dq.push_back(o_sram_wdata);
    end
    if (o_clr_done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_window(input logic [31:0] c, input logic [31:0] r);
    i_col_addr = c;
    i_row_addr = r;
    i_sram_waddr_set_req = 1'b1;
    @(negedge i_clk);
    i_sram_waddr_set_req = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic write_once(input string name, input logic [15:0] d, input int exp_addr);
    i_pixel_data = d;
    i_sram_write_req = 1'b1;
    @(negedge i_clk);
    i_sram_write_req = 1'b0;
    check({name, "_we"}, 32'(o_sram_we), 32'd1);
    check({name, "_addr"}, 32'(o_sram_addr), 32'(exp_addr));
    check({name, "_data"}, 32'(o_sram_wdata), 32'(d));
    @(negedge i_clk);
    check({name, "_we_drop"}, 32'(o_sram_we), 32'd0);
  endtask

  task automatic clear_sweep(input string name, input bit with_write, input bit mid_write);
    int bad;
    bad = 0;
    i_pixel_data = 16'hBEEF;
    i_sram_clr_req = 1'b1;
    i_sram_write_req = with_write;
    @(negedge i_clk);
    i_sram_clr_req = 1'b0;
    i_sram_write_req = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      if (i > 0) @(negedge i_clk);
      if (mid_write && i == 100) i_sram_write_req = 1'b1;
      if (mid_write && i == 101) i_sram_write_req = 1'b0;
      if (!(o_sram_we === 1'b1 && o_busy === 1'b1 && o_clr_done === 1'b0 &&
            o_sram_addr === AW'(i) && o_sram_wdata === '0)) bad++;
    end
    check({name, "_sweep_errs"}, 32'(bad), 32'd0);
    @(negedge i_clk);
    check({name, "_busy_end"}, 32'(o_busy), 32'd0);
    check({name, "_done"}, 32'(o_clr_done), 32'd1);
    check({name, "_we_end"}, 32'(o_sram_we), 32'd0);
    @(negedge i_clk);
    check({name, "_done_1cyc"}, 32'(o_clr_done), 32'd0);
  endtask

  initial begin
    int bad;
    vecs[0]  = '{1'b1, 32'h000A000C, 32'h00140015, 16'h1111, 1'b1, 3210};
    vecs[1]  = '{1'b0, 32'h0,        32'h0,        16'h2222, 1'b1, 3211};
    vecs[2]  = '{1'b0, 32'h0,        32'h0,        16'h3333, 1'b1, 3212};
    vecs[3]  = '{1'b0, 32'h0,        32'h0,        16'h4444, 1'b1, 3370};
    vecs[4]  = '{1'b0, 32'h0,        32'h0,        16'h5555, 1'b1, 3371};
    vecs[5]  = '{1'b0, 32'h0,        32'h0,        16'h6666, 1'b1, 3372};
    vecs[6]  = '{1'b0, 32'h0,        32'h0,        16'h7777, 1'b1, 3210};
    vecs[7]  = '{1'b1, 32'h00A000A5, 32'h00000001, 16'h8888, 1'b0, 0};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        16'h9999, 1'b0, 0};
    vecs[9]  = '{1'b0, 32'h0,        32'h0,        16'hAAAA, 1'b0, 0};
    vecs[10] = '{1'b1, 32'h00050006, 32'h00000001, 16'h1234, 1'b1, 5};
    vecs[11] = '{1'b0, 32'h0,        32'h0,        16'h2345, 1'b1, 6};
    vecs[12] = '{1'b0, 32'h0,        32'h0,        16'h3456, 1'b1, 165};
    vecs[13] = '{1'b0, 32'h0,        32'h0,        16'h4567, 1'b1, 166};
    vecs[14] = '{1'b0, 32'h0,        32'h0,        16'h5678, 1'b1, 5};
    vecs[15] = '{1'b1, 32'h009F009F, 32'h007F007F, 16'hFFFF, 1'b1, 20479};
    vecs[16] = '{1'b1, 32'h000A0005, 32'h00030002, 16'h0F0F, 1'b1, 490};
    vecs[17] = '{1'b0, 32'h0,        32'h0,        16'hF0F0, 1'b1, 490};

    i_rst_n = 1'b0;
    i_pixel_data = '0;
    i_col_addr = '0;
    i_row_addr = '0;
    i_sram_clr_req = 1'b0;
    i_sram_write_req = 1'b0;
    i_sram_waddr_set_req = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_addr", 32'(o_sram_addr), 32'd0);
    check("rst_wdata", 32'(o_sram_wdata), 32'd0);
    check("rst_we", 32'(o_sram_we), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_clr_done), 32'd0);

    for (int k = 0; k < 18; k++) begin
      if (vecs[k].set) set_window(vecs[k].col, vecs[k].row);
      i_pixel_data = vecs[k].data;
      i_sram_write_req = 1'b1;
      @(negedge i_clk);
      i_sram_write_req = 1'b0;
      i_pixel_data = ~vecs[k].data;
      check($sformatf("vec%0d_we", k), 32'(o_sram_we), 32'(vecs[k].exp_we));
      if (vecs[k].exp_we) begin
        check($sformatf("vec%0d_addr", k), 32'(o_sram_addr), 32'(vecs[k].exp_addr));
        check($sformatf("vec%0d_data", k), 32'(o_sram_wdata), 32'(vecs[k].data));
      end
      @(negedge i_clk);
      check($sformatf("vec%0d_we_1cyc", k), 32'(o_sram_we), 32'd0);
    end

    // Held 4-cycle pulse gives one write; re-assert after a 1-cycle gap gives another
    set_window(32'h00000009, 32'h00000000);
    aq.delete();
    dq.delete();
    i_pixel_data = 16'hAAAA;
    i_sram_write_req = 1'b1;
    repeat (4) @(negedge i_clk);
    i_sram_write_req = 1'b0;
    @(negedge i_clk);
    i_pixel_data = 16'hBBBB;
    i_sram_write_req = 1'b1;
    @(negedge i_clk);
    i_sram_write_req = 1'b0;
    repeat (3) @(negedge i_clk);
    check("held_write_count", 32'(aq.size()), 32'd2);
    if (aq.size() == 2) begin
      check("held_addr0", 32'(aq[0]), 32'd0);
      check("held_data0", 32'(dq[0]), 32'hAAAA);
      check("held_addr1", 32'(aq[1]), 32'd1);
      check("held_data1", 32'(dq[1]), 32'hBBBB);
    end

    clear_sweep("clr1", 1'b0, 1'b0);
    write_once("post_clr1", 16'hC0DE, 0);

    // clr and write rising together, plus a write mid-sweep: neither moves the cursor
    write_once("pre_clr2", 16'h0101, 1);
    clear_sweep("clr2", 1'b1, 1'b1);
    write_once("post_clr2", 16'h5A5A, 0);
    check("done_count", 32'(done_cnt), 32'd2);

    // Restart mid-sweep, then async reset at sweep address 1000
    bad = 0;
    i_sram_clr_req = 1'b1;
    @(negedge i_clk);
    i_sram_clr_req = 1'b0;
    for (int i = 0; i <= 500; i++) begin
      if (i > 0) @(negedge i_clk);
      if (!(o_sram_we === 1'b1 && o_sram_addr === AW'(i))) bad++;
    end
    i_sram_clr_req = 1'b1;
    @(negedge i_clk);
    i_sram_clr_req = 1'b0;
    for (int j = 0; j <= 1000; j++) begin
      if (j > 0) @(negedge i_clk);
      if (!(o_sram_we === 1'b1 && o_busy === 1'b1 && o_sram_addr === AW'(j))) bad++;
    end
    check("restart_sweep_errs", 32'(bad), 32'd0);
    i_rst_n = 1'b0;
    #1;
    check("arst_we", 32'(o_sram_we), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_addr", 32'(o_sram_addr), 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check("arst_busy_after", 32'(o_busy), 32'd0);
    check("arst_no_done", 32'(done_cnt), 32'd2);
    write_once("post_arst", 16'h7E57, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
